sm_mul_seq: RTL and testbench

//   Parametrised sequential sign-magnitude multiplier for the logic calculator datapath.

---
 rtl/sm_mul_seq_if.sv | 25 ++
 rtl/sm_mul_seq.sv | 81 ++++++++
 tb/tb_sm_mul_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_mul_seq_if.sv
// Start/busy/done handshake and result bundle for the sign-magnitude multiplier.
interface sm_mul_seq_if #(
  parameter int W = 3
);
  localparam int M = W - 1;

  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*M:0]   result;
  logic           zero_flag;
  logic           negative_flag;

  modport master (
    output start, a, b,
    input  busy, done, result, zero_flag, negative_flag
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, zero_flag, negative_flag
  );
endinterface

// File: rtl/sm_mul_seq.sv
// Sequential sign-magnitude multiplier: one shift-add step per clock over the
// W-1 magnitude bits, then one cycle to publish a canonical (no -0) result.
module sm_mul_seq #(
  parameter int W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  sm_mul_seq_if.slave bus
);
  localparam int M  = W - 1;
  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [2*M-1:0]  mcand;
  logic [2*M-1:0]  acc;
  logic [M-1:0]    mplr;
  logic [CW-1:0]   cnt;
  logic            sgn;

  logic [2*M-1:0]  acc_step;
  logic            res_sgn;

  // Partial product for the current multiplier bit; sign suppressed on zero magnitude
  always_comb begin
    acc_step = mplr[0] ? acc + (mcand << cnt) : acc;
    res_sgn  = sgn && (|acc);
  end

  // Control FSM and datapath; all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      mcand             <= '0;
      acc               <= '0;
      mplr              <= '0;
      cnt               <= '0;
      sgn               <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.result        <= '0;
      bus.zero_flag     <= 1'b1;
      bus.negative_flag <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new start too, giving back-to-back operation
          if (bus.start) begin
            mcand    <= {{M{1'b0}}, bus.a[M-1:0]};
            mplr     <= bus.b[M-1:0];
            sgn      <= bus.a[W-1] ^ bus.b[W-1];
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          // All M steps are always taken; the extra edge publishes the result
          if (cnt == CW'(M)) begin
            bus.result        <= {res_sgn, acc};
            bus.zero_flag     <= (acc == '0);
            bus.negative_flag <= res_sgn;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b1;
            state             <= DONE;
          end else begin
            acc  <= acc_step;
            mplr <= mplr >> 1;
            cnt  <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_mul_seq.sv
// Randomized self-checking bench for sm_mul_seq at W=3 and W=8.
module tb_sm_mul_seq;
  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  sm_mul_seq_if #(.W(3)) if3 ();
  sm_mul_seq_if #(.W(8)) if8 ();

  sm_mul_seq #(.W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  sm_mul_seq #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact magnitude product, sign is xor of signs unless product is zero
  function automatic logic [4:0] ref3(input logic [2:0] x, input logic [2:0] y);
    int unsigned mag;
    logic [3:0]  m;
    mag = int'(x[1:0]) * int'(y[1:0]);
    m   = 4'(mag);
    return {(x[2] ^ y[2]) && (mag != 0), m};
  endfunction

  function automatic logic [14:0] ref8(input logic [7:0] x, input logic [7:0] y);
    int unsigned mag;
    logic [13:0] m;
    mag = int'(x[6:0]) * int'(y[6:0]);
    m   = 14'(mag);
    return {(x[7] ^ y[7]) && (mag != 0), m};
  endfunction

  task automatic run3(input logic [2:0] x, input logic [2:0] y, output int lat,
                      output logic [4:0] res, output logic z, output logic n);
    @(negedge clk);
    if3.start = 1'b1; if3.a = x; if3.b = y;
    @(negedge clk);
    if3.start = 1'b0; if3.a = 3'($urandom); if3.b = 3'($urandom);
    lat = 0;
    while (!if3.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!if3.done) lat = -1;
    res = if3.result; z = if3.zero_flag; n = if3.negative_flag;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, output int lat,
                      output logic [14:0] res, output logic z, output logic n,
                      output logic hs_ok);
    hs_ok = 1'b1;
    @(negedge clk);
    if8.start = 1'b1; if8.a = x; if8.b = y;
    @(negedge clk);
    if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
    lat = 0;
    while (!if8.done && lat < 40) begin
      if (!if8.busy) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!if8.done) lat = -1;
    if (if8.busy) hs_ok = 1'b0;
    res = if8.result; z = if8.zero_flag; n = if8.negative_flag;
    @(negedge clk);
    if (if8.done || if8.busy) hs_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if3.start = 1'b0; if3.a = '0; if3.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({if8.busy, if8.done, if8.zero_flag, if8.negative_flag} !== 4'b0010) begin
      err_cnt++;
      $display("FAIL reset_flags8: got %b expected 0010",
               {if8.busy, if8.done, if8.zero_flag, if8.negative_flag});
    end
    vec_cnt++;
    if (if8.result !== 15'h0) begin
      err_cnt++; $display("FAIL reset_result8: got %h expected 0", if8.result);
    end
    vec_cnt++;
    if ({if3.busy, if3.done, if3.zero_flag, if3.negative_flag, if3.result} !== 9'b0010_00000) begin
      err_cnt++;
      $display("FAIL reset_state3: got %b expected 001000000",
               {if3.busy, if3.done, if3.zero_flag, if3.negative_flag, if3.result});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_w3;
    int lat; logic [4:0] res, exp_r; logic z, n;
    run3(3'b011, 3'b110, lat, res, z, n);
    vec_cnt++;
    if ({lat == 3, res, z, n} !== {1'b1, 5'b10110, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL w3_p3_m2: got lat=%0d res=%b z=%b n=%b expected lat=3 res=10110 z=0 n=1",
               lat, res, z, n);
    end
    run3(3'b100, 3'b011, lat, res, z, n);
    vec_cnt++;
    if ({res, z, n} !== {5'b00000, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL w3_neg_zero: got res=%b z=%b n=%b expected res=00000 z=1 n=0", res, z, n);
    end
    for (int i = 0; i < 64; i++) begin
      logic [5:0] ab;
      ab    = 6'(i);
      exp_r = ref3(ab[5:3], ab[2:0]);
      run3(ab[5:3], ab[2:0], lat, res, z, n);
      vec_cnt++;
      if (lat !== 3 || res !== exp_r || z !== (exp_r[3:0] == 4'd0) || n !== exp_r[4]) begin
        err_cnt++;
        $display("FAIL w3_exhaustive a=%b b=%b: got lat=%0d res=%b z=%b n=%b expected lat=3 res=%b",
                 ab[5:3], ab[2:0], lat, res, z, n, exp_r);
      end
    end
  endtask

  task automatic test_w8_random;
    int lat; logic [14:0] res, exp_r; logic z, n, hs;
    logic [7:0] x, y;
    run8(8'hFF, 8'hFF, lat, res, z, n, hs);
    vec_cnt++;
    if (lat !== 8 || res !== 15'h3F01 || z !== 1'b0 || n !== 1'b0 || hs !== 1'b1) begin
      err_cnt++;
      $display("FAIL w8_max: got lat=%0d res=%h z=%b n=%b hs=%b expected lat=8 res=3f01 z=0 n=0 hs=1",
               lat, res, z, n, hs);
    end
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: x = 8'h80;
        1: x = 8'h7F;
        default: x = 8'($urandom);
      endcase
      y = (i % 7 == 0) ? 8'h00 : 8'($urandom);
      exp_r = ref8(x, y);
      run8(x, y, lat, res, z, n, hs);
      vec_cnt++;
      if (lat !== 8 || res !== exp_r || z !== (exp_r[13:0] == 14'd0) ||
          n !== exp_r[14] || hs !== 1'b1) begin
        err_cnt++;
        $display("FAIL w8_rand a=%h b=%h: got lat=%0d res=%h z=%b n=%b hs=%b expected lat=8 res=%h hs=1",
                 x, y, lat, res, z, n, hs, exp_r);
      end
      if (i % 8 == 0) begin
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (if8.result !== exp_r) begin
          err_cnt++;
          $display("FAIL w8_hold: got %h expected %h", if8.result, exp_r);
        end
      end
    end
  endtask

  task automatic test_busy_ignore;
    int ndone, lat_first; logic [14:0] r;
    ndone = 0; lat_first = -1; r = '0;
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'd5; if8.b = 8'd5;
    @(negedge clk);
    for (int k = 0; k < 25; k++) begin
      if (if8.done) begin
        ndone++;
        if (lat_first < 0) begin lat_first = k; r = if8.result; end
      end
      if8.start = (k == 2);
      if8.a     = (k == 2) ? 8'd2 : 8'd5;
      @(negedge clk);
    end
    vec_cnt++;
    if (ndone !== 1 || lat_first !== 8 || r !== 15'd25) begin
      err_cnt++;
      $display("FAIL busy_ignore: got dones=%0d lat=%0d res=%h expected dones=1 lat=8 res=0019",
               ndone, lat_first, r);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'd10; if8.b = 8'd6;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 40) begin @(negedge clk); lat++; end
    vec_cnt++;
    if (lat !== 8 || if8.result !== 15'd60) begin
      err_cnt++;
      $display("FAIL b2b_first: got lat=%0d res=%h expected lat=8 res=003c", lat, if8.result);
    end
    if8.start = 1'b1; if8.a = 8'h03; if8.b = 8'h84;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 40) begin @(negedge clk); lat++; end
    vec_cnt++;
    if (lat !== 8 || if8.result !== 15'h400C || if8.negative_flag !== 1'b1 ||
        if8.zero_flag !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_second: got lat=%0d res=%h n=%b z=%b expected lat=8 res=400c n=1 z=0",
               lat, if8.result, if8.negative_flag, if8.zero_flag);
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone, lat; logic [14:0] res; logic z, n, hs;
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h7F; if8.b = 8'h7F;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({if8.busy, if8.done, if8.zero_flag, if8.negative_flag} !== 4'b0010 ||
        if8.result !== 15'h0) begin
      err_cnt++;
      $display("FAIL mid_reset: got busy=%b done=%b z=%b n=%b res=%h expected 0 0 1 0 0000",
               if8.busy, if8.done, if8.zero_flag, if8.negative_flag, if8.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (if8.done) ndone++;
    end
    vec_cnt++;
    if (ndone !== 0) begin
      err_cnt++; $display("FAIL mid_reset_no_done: got %0d dones expected 0", ndone);
    end
    run8(8'h86, 8'h07, lat, res, z, n, hs);
    vec_cnt++;
    if (lat !== 8 || res !== ref8(8'h86, 8'h07) || hs !== 1'b1) begin
      err_cnt++;
      $display("FAIL post_reset_op: got lat=%0d res=%h expected lat=8 res=%h",
               lat, res, ref8(8'h86, 8'h07));
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_w3();
    test_w8_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
